// File: rtl/tictactoe_board_ctrl.sv
// Tic-tac-toe board owner and player/computer move sequencer.
// Optional AUTO_COMPUTER_EN: computer takes the lowest-index empty cell.
module tictactoe_board_ctrl #(
   parameter int CELLS = 9,
   parameter int CNT_W = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             play,
   input  logic             pc,
   input  logic [3:0]       player_loc,
   input  logic [3:0]       computer_loc,
   input  logic             illegal_move,
   input  logic             win,
   output logic [1:0]       pos1,
   output logic [1:0]       pos2,
   output logic [1:0]       pos3,
   output logic [1:0]       pos4,
   output logic [1:0]       pos5,
   output logic [1:0]       pos6,
   output logic [1:0]       pos7,
   output logic [1:0]       pos8,
   output logic [1:0]       pos9,
   output logic [CELLS-1:0] PL_en,
   output logic [CELLS-1:0] PC_en,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] move_count,
   output logic             move_err,
   output logic             game_over
);

   typedef enum logic [2:0] {
      IDLE     = 3'b000,
      PL_CHK   = 3'b001,
      CPU_WAIT = 3'b010,
      PC_CHK   = 3'b011,
      DONE     = 3'b100
   } state_t;

   localparam logic [CNT_W-1:0] FULL = CNT_W'(CELLS);

   state_t           st, st_d;
   logic [1:0]       cells   [CELLS];
   logic [1:0]       cells_d [CELLS];
   logic [CELLS-1:0] pl_d, pc_d;
   logic [CNT_W-1:0] cnt_d;
   logic             err_d;
   logic             wr_clash;
   logic             full;

   assign full = (move_count == FULL);

`ifdef AUTO_COMPUTER_EN
   logic [CELLS-1:0] auto_en;
   logic             unused_auto;
   assign unused_auto = ^{pc, computer_loc};

   // Descending scan so the lowest empty index is the one left standing
   always_comb begin
      auto_en = '0;
      for (int k = CELLS - 1; k >= 0; k--)
         if (cells[k] == 2'b00) auto_en = CELLS'(1) << k;
   end
`endif

   always_comb begin
      st_d     = st;
      pl_d     = PL_en;
      pc_d     = PC_en;
      cnt_d    = move_count;
      err_d    = 1'b0;
      wr_clash = 1'b0;
      for (int k = 0; k < CELLS; k++) cells_d[k] = cells[k];
      unique case (st)
         IDLE: begin
            if (win || full) begin
               st_d = DONE;
            end else if (play) begin
               if (player_loc < 4'd9) begin
                  pl_d = CELLS'(1) << player_loc;
                  st_d = PL_CHK;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         PL_CHK: begin
            pl_d = '0;
            if (illegal_move) begin
               err_d = 1'b1;
               st_d  = IDLE;
            end else begin
               for (int k = 0; k < CELLS; k++) begin
                  if (PL_en[k]) begin
                     wr_clash   = wr_clash | (cells[k] != 2'b00);
                     cells_d[k] = 2'b01;
                  end
               end
               if (!full) cnt_d = move_count + CNT_W'(1);
               st_d = CPU_WAIT;
            end
         end
         CPU_WAIT: begin
            if (win || full) begin
               st_d = DONE;
            end else begin
`ifdef AUTO_COMPUTER_EN
               pc_d = auto_en;
               st_d = PC_CHK;
`else
               if (pc) begin
                  if (computer_loc < 4'd9) begin
                     pc_d = CELLS'(1) << computer_loc;
                     st_d = PC_CHK;
                  end else begin
                     err_d = 1'b1;
                  end
               end
`endif
            end
         end
         PC_CHK: begin
            pc_d = '0;
            if (illegal_move) begin
               err_d = 1'b1;
               st_d  = CPU_WAIT;
            end else begin
               for (int k = 0; k < CELLS; k++) begin
                  if (PC_en[k]) begin
                     wr_clash   = wr_clash | (cells[k] != 2'b00);
                     cells_d[k] = 2'b10;
                  end
               end
               if (!full) cnt_d = move_count + CNT_W'(1);
               st_d = IDLE;
            end
         end
         DONE: begin
            st_d = DONE;
         end
         default: begin
            st_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         st         <= IDLE;
         PL_en      <= '0;
         PC_en      <= '0;
         move_count <= '0;
         move_err   <= 1'b0;
         for (int k = 0; k < CELLS; k++) cells[k] <= 2'b00;
      end else begin
         // An occupied target here means the detector let a bad move through
         assert (!wr_clash);
         st         <= st_d;
         PL_en      <= pl_d;
         PC_en      <= pc_d;
         move_count <= cnt_d;
         move_err   <= err_d;
         for (int k = 0; k < CELLS; k++) cells[k] <= cells_d[k];
      end
   end

   assign pos1      = cells[0];
   assign pos2      = cells[1];
   assign pos3      = cells[2];
   assign pos4      = cells[3];
   assign pos5      = cells[4];
   assign pos6      = cells[5];
   assign pos7      = cells[6];
   assign pos8      = cells[7];
   assign pos9      = cells[8];
   assign state     = st;
   assign game_over = (st == DONE);

endmodule

// File: tb/tb_tictactoe_board_ctrl.sv
// Directed bench for tictactoe_board_ctrl with detector/winner models.
module tb_tictactoe_board_ctrl;

   logic       clock;
   logic       reset;
   logic       play;
   logic       pc;
   logic [3:0] player_loc;
   logic [3:0] computer_loc;
   logic       illegal_move;
   logic       win;
   logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9;
   logic [8:0] PL_en;
   logic [8:0] PC_en;
   logic [2:0] state;
   logic [3:0] move_count;
   logic       move_err;
   logic       game_over;

   int errors = 0;
   int checks = 0;

   tictactoe_board_ctrl dut (
      .clock        (clock),
      .reset        (reset),
      .play         (play),
      .pc           (pc),
      .player_loc   (player_loc),
      .computer_loc (computer_loc),
      .illegal_move (illegal_move),
      .win          (win),
      .pos1         (pos1),
      .pos2         (pos2),
      .pos3         (pos3),
      .pos4         (pos4),
      .pos5         (pos5),
      .pos6         (pos6),
      .pos7         (pos7),
      .pos8         (pos8),
      .pos9         (pos9),
      .PL_en        (PL_en),
      .PC_en        (PC_en),
      .state        (state),
      .move_count   (move_count),
      .move_err     (move_err),
      .game_over    (game_over)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   logic [17:0] board;
   logic [8:0]  occ, xs, os;

   function automatic logic line3(input logic [8:0] m);
      line3 = (m[0] & m[1] & m[2]) | (m[3] & m[4] & m[5]) |
              (m[6] & m[7] & m[8]) | (m[0] & m[3] & m[6]) |
              (m[1] & m[4] & m[7]) | (m[2] & m[5] & m[8]) |
              (m[0] & m[4] & m[8]) | (m[2] & m[4] & m[6]);
   endfunction

   // Environment: illegal-move detector and winner detector
   always_comb begin
      board = {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1};
      occ = '0;
      xs  = '0;
      os  = '0;
      for (int k = 0; k < 9; k++) begin
         occ[k] = (board[2*k +: 2] != 2'b00);
         xs[k]  = (board[2*k +: 2] == 2'b01);
         os[k]  = (board[2*k +: 2] == 2'b10);
      end
      illegal_move = |((PL_en | PC_en) & occ);
      win = line3(xs) | line3(os);
   end

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic pmove(input logic [3:0] loc);
      play = 1'b1;
      player_loc = loc;
      tick();
      play = 1'b0;
      tick();
   endtask

   task automatic cmove(input logic [3:0] loc);
      pc = 1'b1;
      computer_loc = loc;
      tick();
      pc = 1'b0;
      tick();
   endtask

   initial begin
      reset = 1'b1;
      play = 1'b0;
      pc = 1'b0;
      player_loc = '0;
      computer_loc = '0;
      tick();
      tick();
      reset = 1'b0;

      check("rst_state", 32'(state), 32'h0);
      check("rst_board", 32'(board), 32'h0);
      check("rst_pl_en", 32'(PL_en), 32'h0);
      check("rst_pc_en", 32'(PC_en), 32'h0);
      check("rst_count", 32'(move_count), 32'h0);
      check("rst_err", 32'(move_err), 32'h0);
      check("rst_over", 32'(game_over), 32'h0);

`ifdef AUTO_COMPUTER_EN
      pmove(4'd0);
      check("a_wait", 32'(state), 32'h2);
      tick();
      check("a_pcchk", 32'(state), 32'h3);
      check("a_pc_en1", 32'(PC_en), 32'h002);
      tick();
      check("a_pos2", 32'(pos2), 32'h2);
      check("a_idle", 32'(state), 32'h0);
      pmove(4'd3);
      tick();
      check("a_pc_en2", 32'(PC_en), 32'h004);
`else
      play = 1'b1;
      player_loc = 4'd4;
      tick();
      play = 1'b0;
      check("t1_plchk", 32'(state), 32'h1);
      check("t1_pl_en", 32'(PL_en), 32'h010);
      tick();
      check("t1_pos5", 32'(pos5), 32'h1);
      check("t1_count", 32'(move_count), 32'h1);
      check("t1_wait", 32'(state), 32'h2);
      check("t1_pl_clr", 32'(PL_en), 32'h0);

      pc = 1'b1;
      computer_loc = 4'd4;
      tick();
      pc = 1'b0;
      check("t2_pcchk", 32'(state), 32'h3);
      check("t2_pc_en", 32'(PC_en), 32'h010);
      tick();
      check("t2_wait", 32'(state), 32'h2);
      check("t2_err", 32'(move_err), 32'h1);
      check("t2_pos5", 32'(pos5), 32'h1);
      check("t2_count", 32'(move_count), 32'h1);
      check("t2_pc_clr", 32'(PC_en), 32'h0);
      tick();
      check("t2_err_off", 32'(move_err), 32'h0);

      cmove(4'd0);
      check("c0_pos1", 32'(pos1), 32'h2);
      check("c0_count", 32'(move_count), 32'h2);
      check("c0_idle", 32'(state), 32'h0);

      play = 1'b1;
      player_loc = 4'd12;
      tick();
      play = 1'b0;
      check("t3_idle", 32'(state), 32'h0);
      check("t3_err", 32'(move_err), 32'h1);
      check("t3_pl_en", 32'(PL_en), 32'h0);
      tick();
      check("t3_err_off", 32'(move_err), 32'h0);

      reset = 1'b1;
      tick();
      reset = 1'b0;
      play = 1'b1;
      player_loc = 4'd0;
      tick();
      play = 1'b0;
      check("rm_plchk", 32'(state), 32'h1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rm_pos1", 32'(pos1), 32'h0);
      check("rm_pl_en", 32'(PL_en), 32'h0);
      check("rm_idle", 32'(state), 32'h0);
      check("rm_count", 32'(move_count), 32'h0);

      pmove(4'd0);
      cmove(4'd3);
      pmove(4'd1);
      cmove(4'd4);
      pmove(4'd2);
      check("w_wait", 32'(state), 32'h2);
      check("w_row", 32'(board[5:0]), 32'h15);
      tick();
      check("w_done", 32'(state), 32'h4);
      check("w_over", 32'(game_over), 32'h1);
      play = 1'b1;
      player_loc = 4'd5;
      tick();
      play = 1'b0;
      tick();
      check("w_stay", 32'(state), 32'h4);
      check("w_pos6", 32'(pos6), 32'h0);
      check("w_count", 32'(move_count), 32'h5);
      check("w_pl_en", 32'(PL_en), 32'h0);

      reset = 1'b1;
      tick();
      reset = 1'b0;
      pmove(4'd0);
      cmove(4'd1);
      pmove(4'd2);
      cmove(4'd4);
      pmove(4'd3);
      cmove(4'd5);
      pmove(4'd7);
      cmove(4'd6);
      check("d_count8", 32'(move_count), 32'h8);
      pmove(4'd8);
      check("d_count9", 32'(move_count), 32'h9);
      check("d_board", 32'(board), 32'h16A59);
      check("d_wait", 32'(state), 32'h2);
      tick();
      check("d_done", 32'(state), 32'h4);
      pc = 1'b1;
      computer_loc = 4'd0;
      play = 1'b1;
      player_loc = 4'd0;
      tick();
      pc = 1'b0;
      play = 1'b0;
      tick();
      check("d_sat", 32'(move_count), 32'h9);
      check("d_stay", 32'(state), 32'h4);
      check("d_over", 32'(game_over), 32'h1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
